// File: rtl/map_ram_port_arbiter_if.sv
// Port-B bundle between the map RAM requesters, the RAM and the arbiter.
// slave: arbiter side. master: requester/RAM side.
interface map_ram_port_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]     req;
  logic [NREQ*5-1:0]   addr_in;
  logic [NREQ*160-1:0] wrdata_in;
  logic [NREQ-1:0]     wren_in;
  logic [159:0]        ram_q;
  logic [NREQ-1:0]     gnt;
  logic [4:0]          ram_addr;
  logic [159:0]        ram_wrdata;
  logic                ram_wren;
  logic [159:0]        rdata;
  logic [NREQ-1:0]     rdvalid;
  logic                busy;
  logic                timeout_err;

  modport slave (
    input  req, addr_in, wrdata_in,
    input  wren_in, ram_q,
    output gnt, ram_addr, ram_wrdata,
    output ram_wren, rdata, rdvalid,
    output busy, timeout_err
  );

  modport master (
    output req, addr_in, wrdata_in,
    output wren_in, ram_q,
    input  gnt, ram_addr, ram_wrdata,
    input  ram_wren, rdata, rdvalid,
    input  busy, timeout_err
  );
endinterface

// File: rtl/map_ram_port_arbiter.sv
// Lock-based round-robin arbiter for port B of the 32x160 map RAM.
// Ports: CLOCK_50, reset (sync, active-high), bus (slave modport).
module map_ram_port_arbiter #(
  parameter int NREQ     = 3,
  parameter int MAX_HOLD = 16,
  parameter int PTR_W    = 3
) (
  input logic                   CLOCK_50,
  input logic                   reset,
  map_ram_port_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t           r_state;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_mask;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tout;

  logic [4:0]       w_addr;
  logic [159:0]     w_wd;
  logic             w_we;
  logic             w_reqg;
  logic             w_busy;
  logic             w_force;
  logic             w_rel;
  logic [NREQ-1:0]  w_mask_nx;
  logic [NREQ-1:0]  w_elig;
  logic [PTR_W-1:0] w_ptr_nx;
  logic [PTR_W-1:0] w_base;
  logic [PTR_W-1:0] w_pick;

  always_comb begin
    w_addr = '0;
    w_wd   = '0;
    w_we   = 1'b0;
    w_reqg = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gnt[i]) begin
        w_addr = bus.addr_in[5*i +: 5];
        w_wd   = bus.wrdata_in[160*i +: 160];
        w_we   = bus.wren_in[i];
        w_reqg = bus.req[i];
      end
    end
  end

  assign w_busy  = (r_state == S_GRANT);
  // Release happens on the edge that would make the count MAX_HOLD,
  // so the grant lasts exactly MAX_HOLD cycles.
  assign w_force = w_busy & w_reqg &
                   (r_cnt == CNT_W'(MAX_HOLD - 1));
  assign w_rel   = w_busy & (~w_reqg | w_force);

  assign w_ptr_nx = (r_idx == PTR_W'(NREQ - 1)) ?
                    '0 : r_idx + PTR_W'(1);

  // A forced-out requester stays masked until it drops req.
  assign w_mask_nx = (r_mask & bus.req) |
                     (w_force ? r_gnt : '0);
  assign w_elig    = bus.req & ~w_mask_nx;
  assign w_base    = w_busy ? w_ptr_nx : r_ptr;

  // Smallest forward distance from w_base wins; descending k
  // lets the nearest candidate overwrite farther ones.
  always_comb begin
    w_pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_elig[i] &&
            ((i == int'(w_base) + k) ||
             (i == int'(w_base) + k - NREQ)))
          w_pick = PTR_W'(i);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_mask  <= '0;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_tout  <= 1'b0;
    end else begin
      r_mask <= w_mask_nx;
      unique case (r_state)
        S_IDLE: begin
          if (|w_elig) begin
            r_state <= S_GRANT;
            r_gnt   <= NREQ'(1) << w_pick;
            r_idx   <= w_pick;
            r_cnt   <= '0;
          end
        end
        S_GRANT: begin
          if (w_rel) begin
            r_ptr <= w_ptr_nx;
            if (w_force)
              r_tout <= 1'b1;
            if (|w_elig) begin
              r_gnt <= NREQ'(1) << w_pick;
              r_idx <= w_pick;
              r_cnt <= '0;
            end else begin
              r_state <= S_IDLE;
              r_gnt   <= '0;
              r_cnt   <= '0;
            end
          end else if (r_cnt != CNT_W'(MAX_HOLD)) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.ram_addr    = w_addr;
  assign bus.ram_wrdata  = w_wd;
  assign bus.ram_wren    = w_we & w_reqg;
  assign bus.rdata       = bus.ram_q;
  // The first grant cycle only presents the address.
  assign bus.rdvalid     = (r_cnt != '0) ? r_gnt : '0;
  assign bus.busy        = w_busy;
  assign bus.timeout_err = r_tout;
endmodule
